if_id_fetch_stage: RTL
======================

Name: if_id_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the control-unit decoder. It holds the PC and a small word-addressed instruction memory, and presents the latched instruction with its opcode field Op[5:0]. It supports stall, flush and branch redirect from later stages, and keeps a saturating count of fetched instructions for debug.

Parameters:
IMEM_DEPTH, 64, number of 32-bit instruction words; must be a power of 2.
AW, 6, instruction-memory word-address width, equal to log2(IMEM_DEPTH).
RESET_PC, 32'h0000_0000, PC value after reset; must be word aligned.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hold the PC and the IF/ID register.
flush  in  1  replace the IF/ID contents with a bubble.
branch_taken  in  1  redirect the PC to branch_target.
branch_target  in  32  redirect address; bits [1:0] are ignored.
imem_we  in  1  instruction-memory write enable (program load).
imem_waddr  in  AW  instruction-memory word address for writes.
imem_wdata  in  32  instruction word to write.
pc_out  out  32  current fetch PC.
ifid_instr  out  32  latched instruction word.
ifid_pc4  out  32  latched PC+4 of that instruction.
ifid_valid  out  1  IF/ID holds a real instruction, not a bubble.
Op  out  6  ifid_instr[31:26]; feeds the control unit.
fetch_count  out  16  number of instructions latched into IF/ID, saturating.

Behaviour:
- Reset, asynchronous and taking effect immediately on rst_n low:
  - pc_out = RESET_PC
  - ifid_instr = 0, ifid_pc4 = 0, ifid_valid = 0, Op = 0
  - fetch_count = 0
  - Instruction-memory contents are not affected by reset.
- Bubble encoding is ifid_instr = 32'h0000_0000 with ifid_valid = 0. An all-zero word decodes as an R-type writing $0, so it is architecturally harmless.
- Memory read:
  - Combinational read, imem[pc_out[AW+1:2]].
  - Higher PC bits are ignored, so the word index wraps modulo IMEM_DEPTH.
- Memory write:
  - Synchronous write when imem_we = 1.
  - If the written address equals the word being fetched in the same cycle, IF/ID captures the OLD word (read-before-write).
- Per-edge update, in priority order:
  1. branch_taken = 1 (overrides stall and flush): pc_out <= {branch_target[31:2], 2'b00}; IF/ID <= bubble; fetch_count unchanged.
  2. Otherwise, flush = 1:
     - IF/ID <= bubble.
     - pc_out <= pc_out + 4 if stall = 0, otherwise pc_out is held.
     - fetch_count unchanged.
  3. Otherwise, stall = 1: pc_out and all IF/ID fields hold; fetch_count unchanged.
  4. Otherwise (normal fetch):
     - ifid_instr <= imem[pc_out index]
     - ifid_pc4 <= pc_out + 4
     - ifid_valid <= 1
     - pc_out <= pc_out + 4
     - fetch_count <= fetch_count + 1, saturating at 16'hFFFF
- Latency: the word at PC p appears on ifid_instr and Op exactly one clock after pc_out = p, in a non-stalled, non-redirected cycle.
- PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Op is always ifid_instr[31:26], so Op = 0 during bubbles.
- Reset asserted mid-operation (including during a stall or redirect) clears state immediately. The first fetch after rst_n rises uses RESET_PC.

Test Plan:
1. Load imem[0..3] = 32'h0000_0020, 32'h8C01_0004, 32'hAC01_0008, 32'h1000_FFFF; release reset; no stall.
   - After edge 1: ifid_instr = 32'h0000_0020, Op = 6'b000000, ifid_pc4 = 4.
   - After edge 2: Op = 6'b100011.
   - fetch_count = 4 after 4 edges.
2. Assert stall for 3 cycles while pc_out = 8: pc_out stays 8, ifid_instr stays 32'h8C01_0004, fetch_count stays 2. On release, ifid_instr = 32'hAC01_0008.
3. branch_taken = 1 with branch_target = 32'h0000_0007, and stall = 1 in the same cycle:
   - next pc_out = 4, ifid_valid = 0, ifid_instr = 0.
   - the following edge latches imem[1].
4. flush = 1 alone at pc_out = 4 → ifid_valid = 0, Op = 0, pc_out = 8. flush = 1 together with stall = 1 → bubble latched, pc_out held.
5. With IMEM_DEPTH = 64, branch to 32'h0000_0100 → fetches imem[0]. Branch to 32'hFFFF_FFFC, then one fetch → pc_out = 0.
6. Address-conflict and reset checks:
   - imem_we to the word currently being fetched → IF/ID gets the old word; the next fetch of that address gets the new word.
   - Assert rst_n low between edges → all outputs clear immediately, without waiting for a clock edge.
   - Preload fetch_count near 16'hFFFF (force) → it saturates and does not wrap.

Source files
------------

// File: rtl/if_id_fetch_stage_if.sv
// Bus between the fetch stage and its environment: pipeline control from later
// stages, the program-load port, and the IF/ID register contents seen by decode.
interface if_id_fetch_stage_if #(
  parameter int AW = 6
);
  logic          stall;
  logic          flush;
  logic          branch_taken;
  logic [31:0]   branch_target;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   pc_out;
  logic [31:0]   ifid_instr;
  logic [31:0]   ifid_pc4;
  logic          ifid_valid;
  logic [5:0]    Op;
  logic [15:0]   fetch_count;

  modport master (
    output stall, flush, branch_taken, branch_target,
    output imem_we, imem_waddr, imem_wdata,
    input  pc_out, ifid_instr, ifid_pc4, ifid_valid, Op, fetch_count
  );

  modport slave (
    input  stall, flush, branch_taken, branch_target,
    input  imem_we, imem_waddr, imem_wdata,
    output pc_out, ifid_instr, ifid_pc4, ifid_valid, Op, fetch_count
  );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: PC, word-addressed
// instruction memory, stall/flush/redirect handling and a saturating fetch counter.
module if_id_fetch_stage #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          AW         = 6,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst_n,
  if_id_fetch_stage_if.slave bus
);

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [15:0] COUNT_MAX    = 16'hFFFF;

  logic [31:0] imem_r [IMEM_DEPTH];

  logic [31:0] pc_r;
  logic [31:0] ifidInstr_r;
  logic [31:0] ifidPc4_r;
  logic        ifidValid_r;
  logic [15:0] fetchCount_r;

  logic [31:0] pcPlus4_s;
  logic [31:0] fetchWord_s;
  logic [31:0] targetAligned_s;
  logic [31:0] pcNext_s;
  logic [31:0] instrNext_s;
  logic [31:0] pc4Next_s;
  logic        validNext_s;
  logic [15:0] countNext_s;

  // Combinational read; upper PC bits drop out so the index wraps modulo the depth.
  assign fetchWord_s     = imem_r[pc_r[AW+1:2]];
  assign pcPlus4_s       = pc_r + 32'd4;
  assign targetAligned_s = bus.branch_target & ~32'd3;

  // Program-load write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      imem_r[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  // Next-state selection: redirect beats flush, flush beats stall, else fetch.
  always_comb begin
    pcNext_s    = pc_r;
    instrNext_s = ifidInstr_r;
    pc4Next_s   = ifidPc4_r;
    validNext_s = ifidValid_r;
    countNext_s = fetchCount_r;
    if (bus.branch_taken) begin
      pcNext_s    = targetAligned_s;
      instrNext_s = BUBBLE_INSTR;
      pc4Next_s   = 32'h0000_0000;
      validNext_s = 1'b0;
    end else if (bus.flush) begin
      instrNext_s = BUBBLE_INSTR;
      pc4Next_s   = 32'h0000_0000;
      validNext_s = 1'b0;
      if (bus.stall) begin
        pcNext_s = pc_r;
      end else begin
        pcNext_s = pcPlus4_s;
      end
    end else if (bus.stall) begin
      pcNext_s = pc_r;
    end else begin
      pcNext_s    = pcPlus4_s;
      instrNext_s = fetchWord_s;
      pc4Next_s   = pcPlus4_s;
      validNext_s = 1'b1;
      if (fetchCount_r == COUNT_MAX) begin
        countNext_s = fetchCount_r;
      end else begin
        countNext_s = fetchCount_r + 16'd1;
      end
    end
  end

  // PC, IF/ID register and fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r         <= RESET_PC;
      ifidInstr_r  <= BUBBLE_INSTR;
      ifidPc4_r    <= 32'h0000_0000;
      ifidValid_r  <= 1'b0;
      fetchCount_r <= 16'h0000;
    end else begin
      pc_r         <= pcNext_s;
      ifidInstr_r  <= instrNext_s;
      ifidPc4_r    <= pc4Next_s;
      ifidValid_r  <= validNext_s;
      fetchCount_r <= countNext_s;
    end
  end

  assign bus.pc_out      = pc_r;
  assign bus.ifid_instr  = ifidInstr_r;
  assign bus.ifid_pc4    = ifidPc4_r;
  assign bus.ifid_valid  = ifidValid_r;
  assign bus.Op          = ifidInstr_r[31:26];
  assign bus.fetch_count = fetchCount_r;

endmodule
